// File: rtl/esm_pkg.sv
// Shared definitions for the ESM shuffle blocks: default sizes and the
// result-entry layout used by both the deshuffler and the issue-index mapper.
package esm_pkg;

  function automatic int esm_iw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ESM_BS = 16;
  localparam int ESM_DW = 32;
  localparam int ESM_IW = esm_iw(ESM_BS);

  typedef struct packed {
    logic [ESM_IW-1:0] buffer_index;
    logic [ESM_DW-1:0] data;
  } esm_entry_t;

endpackage

// File: rtl/esm_core_deshuffle_if.sv
// Bundle of the deshuffler's result-in, result-out, slot-free and status signals.
// The DUT sits on the slave modport; the producer/consumer side uses master.
interface esm_core_deshuffle_if
  import esm_pkg::*;
#(
  parameter int bs = ESM_BS,
  parameter int DW = ESM_DW
);
  localparam int IW = $clog2(bs);
  localparam int CW = $clog2(bs) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_issue_index;
  logic [IW-1:0] in_buffer_index;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_issue_index;
  logic [DW-1:0] out_data;
  logic          free_valid;
  logic [IW-1:0] free_index;
  logic [CW-1:0] occupancy;
  logic          dup_err;

  modport master (
    output in_valid, in_issue_index, in_buffer_index, in_data, out_ready,
    input  in_ready, out_valid, out_issue_index, out_data,
           free_valid, free_index, occupancy, dup_err
  );

  modport slave (
    input  in_valid, in_issue_index, in_buffer_index, in_data, out_ready,
    output in_ready, out_valid, out_issue_index, out_data,
           free_valid, free_index, occupancy, dup_err
  );
endinterface

// File: rtl/esm_deshuffle_store.sv
// Slot array indexed by issue index with a valid bitmap; one write port and
// one read/clear port. The write-side valid bit is exported for duplicate detection.
module esm_deshuffle_store #(
  parameter int bs = 16,
  parameter int DW = 32,
  localparam int IW = $clog2(bs)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_addr,
  input  logic [IW-1:0] wr_buf,
  input  logic [DW-1:0] wr_data,
  output logic          wr_hit,
  input  logic [IW-1:0] rd_addr,
  input  logic          rd_clr,
  output logic          rd_valid,
  output logic [IW-1:0] rd_buf,
  output logic [DW-1:0] rd_data
);

  logic [bs-1:0] valid_r;
  logic [IW-1:0] buf_r  [bs];
  logic [DW-1:0] data_r [bs];

  assign wr_hit   = valid_r[wr_addr];
  assign rd_valid = valid_r[rd_addr];
  assign rd_buf   = buf_r[rd_addr];
  assign rd_data  = data_r[rd_addr];

  // Valid bitmap: a write only targets an empty slot and a clear only a full
  // one, so the two ports never collide on the same bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= '0;
    end else begin
      if (wr_en) begin
        valid_r[wr_addr] <= 1'b1;
      end
      if (rd_clr) begin
        valid_r[rd_addr] <= 1'b0;
      end
    end
  end

  // Payload storage, qualified by the valid bitmap so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_r[wr_addr]  <= wr_buf;
      data_r[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/esm_core_deshuffle.sv
// Restores program order of results executed from randomised buffer slots.
// Optional macro ESM_DESHUFFLE_BYPASS_EN: head-slot results skip the store.
module esm_core_deshuffle
  import esm_pkg::*;
#(
  parameter int bs = ESM_BS,
  parameter int DW = ESM_DW,
  localparam int IW = $clog2(bs),
  localparam int CW = $clog2(bs) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  esm_core_deshuffle_if.slave   bus
);

  logic          accept_s;
  logic          wr_hit_s;
  logic          wr_ok_s;
  logic          dup_s;
  logic          bypass_s;
  logic          rd_valid_s;
  logic [IW-1:0] rd_buf_s;
  logic [DW-1:0] rd_data_s;
  logic          out_free_s;
  logic          load_s;
  logic          handshake_s;

  logic [IW-1:0] head_r;
  logic [CW-1:0] occ_r;
  logic          out_valid_r;
  logic [IW-1:0] out_issue_r;
  logic [DW-1:0] out_data_r;
  logic [IW-1:0] out_buf_r;
  logic          free_valid_r;
  logic [IW-1:0] free_index_r;
  logic          dup_err_r;

  assign bus.in_ready = ~rst;
  assign accept_s     = bus.in_valid & ~rst;
  assign out_free_s   = ~out_valid_r | bus.out_ready;
  assign handshake_s  = out_valid_r & bus.out_ready;
  assign load_s       = rd_valid_s & out_free_s;

`ifdef ESM_DESHUFFLE_BYPASS_EN
  assign bypass_s = accept_s & (bus.in_issue_index == head_r) & ~rd_valid_s & out_free_s;
`else
  assign bypass_s = 1'b0;
`endif

  assign dup_s   = accept_s & wr_hit_s;
  assign wr_ok_s = accept_s & ~wr_hit_s & ~bypass_s;

  esm_deshuffle_store #(
    .bs (bs),
    .DW (DW)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_ok_s),
    .wr_addr  (bus.in_issue_index),
    .wr_buf   (bus.in_buffer_index),
    .wr_data  (bus.in_data),
    .wr_hit   (wr_hit_s),
    .rd_addr  (head_r),
    .rd_clr   (load_s),
    .rd_valid (rd_valid_s),
    .rd_buf   (rd_buf_s),
    .rd_data  (rd_data_s)
  );

  // Output register, head pointer and slot-return pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r       <= '0;
      out_valid_r  <= 1'b0;
      out_issue_r  <= '0;
      out_data_r   <= '0;
      out_buf_r    <= '0;
      free_valid_r <= 1'b0;
      free_index_r <= '0;
    end else begin
      free_valid_r <= handshake_s;
      if (handshake_s) begin
        free_index_r <= out_buf_r;
      end
      if (load_s) begin
        out_valid_r <= 1'b1;
        out_issue_r <= head_r;
        out_data_r  <= rd_data_s;
        out_buf_r   <= rd_buf_s;
        head_r      <= head_r + IW'(1);
      end else if (bypass_s) begin
        out_valid_r <= 1'b1;
        out_issue_r <= head_r;
        out_data_r  <= bus.in_data;
        out_buf_r   <= bus.in_buffer_index;
        head_r      <= head_r + IW'(1);
      end else if (handshake_s) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  // Store occupancy and sticky duplicate flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_r     <= '0;
      dup_err_r <= 1'b0;
    end else begin
      case ({wr_ok_s, load_s})
        2'b10:   occ_r <= occ_r + CW'(1);
        2'b01:   occ_r <= occ_r - CW'(1);
        default: occ_r <= occ_r;
      endcase
      if (dup_s) begin
        dup_err_r <= 1'b1;
      end
    end
  end

  assign bus.out_valid       = out_valid_r;
  assign bus.out_issue_index = out_issue_r;
  assign bus.out_data        = out_data_r;
  assign bus.free_valid      = free_valid_r;
  assign bus.free_index      = free_index_r;
  assign bus.occupancy       = occ_r;
  assign bus.dup_err         = dup_err_r;

endmodule

// File: tb/tb_esm_core_deshuffle.sv
// Directed self-checking bench for esm_core_deshuffle (bs=16, DW=32).
// Expected latency switches on ESM_DESHUFFLE_BYPASS_EN.
module tb_esm_core_deshuffle;
  import esm_pkg::*;

  localparam int BS_T = 16;
  localparam int DW_T = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  esm_core_deshuffle_if #(.bs(BS_T), .DW(DW_T)) bus ();
  esm_core_deshuffle #(.bs(BS_T), .DW(DW_T)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [35:0] oq[$];
  int          ocyc[$];
  logic [3:0]  fq[$];
  int t1_free[4] = '{7, 5, 2, 9};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Handshake/free recorder plus stall-stability check, sampled mid-cycle.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [3:0]  prev_issue;
  always @(negedge clk) begin
    if (bus.free_valid) fq.push_back(bus.free_index);
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_data", 64'(bus.out_data), 64'(prev_data));
        chk("stall_issue", 64'(bus.out_issue_index), 64'(prev_issue));
      end
      if (bus.out_valid && bus.out_ready) begin
        oq.push_back({bus.out_issue_index, bus.out_data});
        ocyc.push_back(cyc);
      end
      prev_stall = bus.out_valid & ~bus.out_ready;
      prev_data  = bus.out_data;
      prev_issue = bus.out_issue_index;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int issue, input int bidx, input logic [31:0] d);
    bus.in_valid        = 1'b1;
    bus.in_issue_index  = 4'(issue);
    bus.in_buffer_index = 4'(bidx);
    bus.in_data         = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    for (int i = 0; i < 64; i++) begin
      if (oq.size() >= n) break;
      step();
    end
    step();
    step();
    chk("out_count", 64'(oq.size()), 64'(n));
  endtask

  task automatic clear_q();
    oq.delete();
    ocyc.delete();
    fq.delete();
  endtask

  initial begin
    logic [35:0] e;
    bus.in_valid = 1'b0; bus.in_issue_index = 4'd0; bus.in_buffer_index = 4'd0;
    bus.in_data = 32'd0; bus.out_ready = 1'b0;

    // Reset state
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_occ", 64'(bus.occupancy), 64'd0);
    chk("rst_dup", 64'(bus.dup_err), 64'd0);
    chk("rst_free_valid", 64'(bus.free_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    step(); step();
    rst = 1'b0;
    step();
    chk("in_ready", 64'(bus.in_ready), 64'd1);

    // Shuffled arrival 3,1,0,2 drained in program order
    clear_q();
    bus.out_ready = 1'b1;
    wr(3, 9, 32'hA3); wr(1, 5, 32'hA1); wr(0, 7, 32'hA0); wr(2, 2, 32'hA2);
    wait_out(4);
    for (int i = 0; i < 4; i++) begin
      e = {4'(i), 32'hA0 + 32'(i)};
      chk("t1_order", 64'(oq[i]), 64'(e));
    end
    chk("t1_free_n", 64'(fq.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk("t1_free_idx", 64'(fq[i]), 64'(t1_free[i]));
    chk("t1_occ", 64'(bus.occupancy), 64'd0);

    // Head-slot latency (head = 4), output stalled
    clear_q();
    bus.out_ready = 1'b0;
    wr(4, 3, 32'hB4);
`ifdef ESM_DESHUFFLE_BYPASS_EN
    chk("lat_n_valid", 64'(bus.out_valid), 64'd1);
    chk("lat_n_occ", 64'(bus.occupancy), 64'd0);
`else
    chk("lat_n_valid", 64'(bus.out_valid), 64'd0);
    chk("lat_n_occ", 64'(bus.occupancy), 64'd1);
`endif
    step();
    chk("lat_n1_valid", 64'(bus.out_valid), 64'd1);
    chk("lat_n1_issue", 64'(bus.out_issue_index), 64'd4);
    chk("lat_n1_data", 64'(bus.out_data), 64'hB4);
    chk("lat_n1_occ", 64'(bus.occupancy), 64'd0);

    // Out-of-order arrivals wait for missing head slot 5
    wr(9, 9, 32'hC9); wr(8, 8, 32'hC8); wr(7, 7, 32'hC7); wr(6, 6, 32'hC6);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("ooo_only_head", 64'(oq.size()), 64'd1);
    chk("ooo_valid", 64'(bus.out_valid), 64'd0);
    chk("ooo_occ", 64'(bus.occupancy), 64'd4);

    // Fill the gap, then drain with out_ready toggling
    bus.out_ready = 1'b0;
    wr(5, 1, 32'hC5);
    for (int i = 0; i < 12; i++) begin
      bus.out_ready = (i % 2 == 0);
      step();
    end
    bus.out_ready = 1'b1;
    wait_out(6);
    for (int i = 1; i < 6; i++) begin
      e = {4'(i + 4), 32'hC4 + 32'(i)};
      chk("tog_order", 64'(oq[i]), 64'(e));
    end
    chk("tog_free_n", 64'(fq.size()), 64'd6);
    chk("tog_free_5", 64'(fq[1]), 64'd1);
    chk("tog_free_9", 64'(fq[5]), 64'd9);

    // Reset mid-operation with output held and five entries stored
    clear_q();
    bus.out_ready = 1'b0;
    for (int i = 10; i < 16; i++) wr(i, i - 10, 32'hD0 + 32'(i));
    chk("pre_rst_occ", 64'(bus.occupancy), 64'd5);
    chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_occ", 64'(bus.occupancy), 64'd0);
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_free", 64'(bus.free_valid), 64'd0);
    bus.out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    step(); step();
    chk("post_rst_outs", 64'(oq.size()), 64'd0);
    chk("post_rst_frees", 64'(fq.size()), 64'd0);
    wr(0, 11, 32'hD0);
    wait_out(1);
    chk("post_rst_data", 64'(oq[0]), 64'({4'd0, 32'hD0}));
    chk("post_rst_free", 64'(fq[0]), 64'd11);

    // Duplicate write to issue 4 after a fresh reset
    rst = 1'b1; step(); rst = 1'b0; step();
    clear_q();
    bus.out_ready = 1'b0;
    wr(4, 4, 32'hE1); wr(4, 12, 32'hE2);
    chk("dup_flag", 64'(bus.dup_err), 64'd1);
    chk("dup_occ", 64'(bus.occupancy), 64'd1);
    for (int i = 0; i < 4; i++) wr(i, i, 32'hF0 + 32'(i));
    bus.out_ready = 1'b1;
    wait_out(5);
    chk("dup_first_kept", 64'(oq[4]), 64'({4'd4, 32'hE1}));
    chk("dup_free", 64'(fq[4]), 64'd4);
    chk("dup_sticky", 64'(bus.dup_err), 64'd1);
    rst = 1'b1;
    #1;
    chk("dup_cleared", 64'(bus.dup_err), 64'd0);
    step(); rst = 1'b0; step();

    // Fill all slots in reverse, then drain back-to-back and wrap
    clear_q();
    bus.out_ready = 1'b0;
    for (int i = 15; i >= 0; i--) wr(i, 15 - i, 32'h5000 + 32'(i));
    step();
    chk("fill_occ", 64'(bus.occupancy), 64'd15);
    chk("fill_valid", 64'(bus.out_valid), 64'd1);
    chk("fill_issue", 64'(bus.out_issue_index), 64'd0);
    bus.out_ready = 1'b1;
    wait_out(16);
    for (int i = 0; i < 16; i++) begin
      e = {4'(i), 32'h5000 + 32'(i)};
      chk("fill_order", 64'(oq[i]), 64'(e));
      chk("fill_free", 64'(fq[i]), 64'(15 - i));
    end
    chk("fill_b2b", 64'(ocyc[15] - ocyc[0]), 64'd15);
    wr(0, 3, 32'h77);
    wait_out(17);
    chk("wrap_head0", 64'(oq[16]), 64'({4'd0, 32'h77}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/esm_core_deshuffle.md
ESM_CORE_DESHUFFLE -- requirements
Module: esm_core_deshuffle

Interface
REQ-001 SHALL have parameter bs, default 16, meaning number of shuffle slots (power of two, >=2).
REQ-002 SHALL have parameter DW, default 32, meaning result data width.
REQ-003 SHALL define IW = $clog2(bs) and CW = $clog2(bs)+1 as derived widths.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  shuffled result presented.
REQ-007 in_ready  output  1  block accepts result.
REQ-008 in_issue_index  input  IW  program-order slot of result.
REQ-009 in_buffer_index  input  IW  randomised buffer slot the result executed from.
REQ-010 in_data  input  DW  result payload.
REQ-011 out_valid  output  1  in-order result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out_issue_index  output  IW  program-order slot of output.
REQ-014 out_data  output  DW  output payload.
REQ-015 free_valid  output  1  one-cycle pulse returning a buffer slot to the issue mapper.
REQ-016 free_index  output  IW  buffer slot being returned.
REQ-017 occupancy  output  CW  entries held in store, output register excluded.
REQ-018 dup_err  output  1  sticky duplicate-write flag.

Function
REQ-019 Per-slot store SHALL hold {valid, buffer_index, data} indexed by issue index; head pointer (IW bits) SHALL mark next program-order slot.
REQ-020 in_ready SHALL be 0 while rst high and 1 otherwise; accept = in_valid & in_ready.
REQ-021 Accept to a slot with valid=0 SHALL write the entry and set valid at that edge.
REQ-022 Accept to a slot with valid=1 SHALL be dropped, store unchanged, dup_err set to 1 and held until reset.
REQ-023 Output register SHALL load when store[head].valid=1 and (out_valid=0 or out_ready=1); load clears store[head].valid and increments head, wrapping bs-1 -> 0.
REQ-024 Output handshake out_valid & out_ready without a new load SHALL clear out_valid next edge; sustained throughput one result per cycle.
REQ-025 out_valid/out_issue_index/out_data SHALL be registered and stable while out_valid=1 and out_ready=0.
REQ-026 Latency without bypass: result accepted at edge N into head slot with empty output SHALL give out_valid=1 after edge N+1.
REQ-027 On each output handshake, free_valid SHALL pulse 1 for exactly the following cycle with free_index = buffer_index of the consumed entry; back-to-back handshakes give consecutive pulses.
REQ-028 occupancy SHALL +1 on a successful write, -1 on a load, hold when both occur same edge; range 0..bs.
REQ-029 Write to a non-head slot and load from head in same cycle SHALL both take effect.
REQ-030 Out-of-order arrivals SHALL wait; head never skips a slot with valid=0.

Reset
REQ-031 rst SHALL asynchronously clear all valid bits, head=0, occupancy=0, out_valid=0, free_valid=0, dup_err=0; out_data, out_issue_index, free_index SHALL reset to 0; store data need not reset.
REQ-032 Reset mid-operation SHALL discard all stored and pending results without a free_valid pulse.

Configuration
REQ-033 Macro ESM_DESHUFFLE_BYPASS_EN defined: accept with in_issue_index==head, store[head].valid=0 and output register loadable SHALL load output directly (out_valid=1 after edge N), skip store, increment head, leave occupancy unchanged.
REQ-034 Macro undefined: no bypass path; all results pass through the store (REQ-026 latency).

Structure
REQ-035 Package esm_pkg SHALL hold default BS, DW, IW width function and the entry struct {buffer_index, data}, shared with the issue-index mapper.
REQ-036 Sub-module esm_deshuffle_store SHALL implement the slot array plus valid bitmap with one write and one read/clear port.

Verification
REQ-037 Reset, write issue 0..3 in order 3,1,0,2 with buffer 9,5,7,2, out_ready=1 -> outputs issue 0,1,2,3 data in order; free_index 7,5,2,9.
REQ-038 Fill all 16 slots reverse order, out_ready=0 -> occupancy 15 with out_valid=1 on issue 0; then out_ready=1 -> 16 consecutive outputs, head wraps to 0.
REQ-039 Write issue 4 twice -> second dropped, dup_err=1 until rst, first data output.
REQ-040 out_ready toggled 1/0 every cycle during drain -> out_data unchanged while stalled; no loss or duplication.
REQ-041 Assert rst with 5 entries stored -> occupancy=0, out_valid=0, no free_valid; post-reset write to issue 0 output normally.
REQ-042 With ESM_DESHUFFLE_BYPASS_EN, empty block, write issue 0 -> out_valid=1 one edge later, occupancy stays 0; without macro, two edges.
